debounce_event_arbiter: RTL and testbench
=========================================

DEBOUNCE_EVENT_ARBITER -- requirements
Module: debounce_event_arbiter

Interface
REQ-001 Parameter CHANNELS, default 4: number of raw button inputs, range 2..16.
REQ-002 Parameter DEBOUNCER_COUNTER_WIDTH, default 3: a change is accepted after 2^DEBOUNCER_COUNTER_WIDTH consecutive differing samples.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  reset, synchronous, active-low.
REQ-005 Input  input  CHANNELS  raw asynchronous button levels.
REQ-006 Stable  output  CHANNELS  debounced levels, registered.
REQ-007 EventValid  output  1  event offered, registered.
REQ-008 EventReady  input  1  consumer accepts the event when high with EventValid.
REQ-009 EventChannel  output  clog2(CHANNELS)  index of the channel that produced the event.
REQ-010 EventType  output  1  1 = press (Stable rose), 0 = release (Stable fell).
REQ-011 Overrun  output  CHANNELS  sticky per-channel lost-event flags.
REQ-012 ClearOverrun  input  CHANNELS  one-cycle pulse clears the matching Overrun bit.

Function
REQ-013 Each Input bit SHALL pass through a 2-flop synchronizer; only synchronized value S[i] is used.
REQ-014 Per channel, a DEBOUNCER_COUNTER_WIDTH-bit counter SHALL increment when S[i] != Stable[i] and clear to 0 when equal.
REQ-015 When counter is all-ones and S[i] != Stable[i], Stable[i] SHALL toggle on that edge and the counter SHALL clear.
REQ-016 Latency: a clean Input edge SHALL appear on Stable 2 + 2^DEBOUNCER_COUNTER_WIDTH cycles later (10 for width 3); any return to equality before then SHALL restart the count.
REQ-017 Each Stable toggle SHALL write a one-entry pending slot for that channel: {valid, type}.
REQ-018 If the slot is already valid and is not being drained that cycle, the new event SHALL be dropped and Overrun[i] set; the existing slot SHALL be kept.
REQ-019 If the slot is drained and a new event arrives on the same edge, the new event SHALL be stored and Overrun SHALL not be set.
REQ-020 Output register SHALL be free when EventValid = 0 or (EventValid and EventReady).
REQ-021 When free, the arbiter SHALL pick the first valid slot in round-robin order starting at pointer P. It SHALL load EventChannel/EventType, set EventValid, clear that slot, and set P = chosen + 1 (mod CHANNELS), all on the same edge.
REQ-022 With no valid slot while free, EventValid SHALL deassert and P SHALL hold.
REQ-023 While EventValid and not EventReady, EventValid, EventChannel and EventType SHALL hold unchanged.
REQ-024 A slot written on edge t SHALL be presentable at the earliest on edge t+1, so EventValid asserts one cycle after the Stable toggle.
REQ-025 Back-to-back: with EventReady held high and slots pending, one event SHALL be delivered per cycle.
REQ-026 ClearOverrun[i] SHALL take priority over a same-cycle overrun set on channel i; the bit ends cleared.

Reset
REQ-027 With Rst_n = 0 at a rising edge, the following SHALL clear to 0: synchronizers, counters, Stable, pending slots, Overrun, EventValid, EventChannel, EventType, and P.
REQ-028 Reset asserted mid-count or with EventValid high SHALL discard all state; no event is offered on the first cycle after release.
REQ-029 Input high throughout reset SHALL produce a press event after release via normal debounce (10 cycles, width 3).

Verification (CHANNELS=4, DEBOUNCER_COUNTER_WIDTH=3)
REQ-030 Input[0] toggles every 2 cycles for 40 cycles, then stays 0 -> Stable = 0, EventValid never asserts.
REQ-031 Input[1] 0->1 and held, EventReady=1 -> Stable[1]=1 exactly 10 cycles after the change; EventValid pulses 1 cycle later with EventChannel=1, EventType=1.
REQ-032 Inputs 0,2,3 rise on the same cycle, EventReady=1, P=0 -> events delivered on consecutive cycles in order 0,2,3, all press; P ends at 0.
REQ-033 Input[2] press, EventReady held 0 -> event stays offered. Input[2] release is stored in the slot; a second press is dropped and Overrun[2]=1. EventReady=1 -> press then release are delivered. ClearOverrun[2] pulse -> Overrun[2]=0.
REQ-034 Rst_n low for 1 cycle while EventValid=1 and Input[3] is mid-count -> all outputs 0 next cycle. Input[3] held high -> press event with EventChannel=3 follows the full 10-cycle debounce.

Source files
------------

// File: rtl/debounce_event_arbiter.sv
// Per-channel synchronizer and debouncer feeding one-deep event slots,
// drained by a round-robin arbiter into a valid/ready event register.
module debounce_event_arbiter #(
  parameter  int CHANNELS = 4,
  parameter  int DEBOUNCER_COUNTER_WIDTH = 3,
  localparam int CW = $clog2(CHANNELS)
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [CHANNELS-1:0] Input,
  output logic [CHANNELS-1:0] Stable,
  output logic                EventValid,
  input  logic                EventReady,
  output logic [CW-1:0]       EventChannel,
  output logic                EventType,
  output logic [CHANNELS-1:0] Overrun,
  input  logic [CHANNELS-1:0] ClearOverrun
);

  logic [CHANNELS-1:0] sync1, sync2;
  logic [CHANNELS-1:0] diff, toggle;
  logic [CHANNELS-1:0] pend_v, pend_t;
  logic [CHANNELS-1:0] drain, ovr_set;
  logic [DEBOUNCER_COUNTER_WIDTH-1:0] cnt [CHANNELS];
  logic [CW-1:0] ptr, pick, nxt;
  logic found, free;
  int idx;

  always_comb begin
    diff = sync2 ^ Stable;
    toggle = '0;
    for (int i = 0; i < CHANNELS; i++)
      toggle[i] = diff[i] && (&cnt[i]);
  end

  // First pending slot at or after ptr, wrapping.
  always_comb begin
    free = !EventValid || EventReady;
    found = 1'b0;
    pick = '0;
    idx = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (!found && pend_v[idx]) begin
        found = 1'b1;
        pick = CW'(idx);
      end
    end
    nxt = CW'((int'(pick) + 1) % CHANNELS);
    drain = '0;
    if (free && found)
      drain[pick] = 1'b1;
    ovr_set = toggle & pend_v & ~drain;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      Stable <= '0;
      pend_v <= '0;
      pend_t <= '0;
      Overrun <= '0;
      EventValid <= 1'b0;
      EventChannel <= '0;
      EventType <= 1'b0;
      ptr <= '0;
      for (int i = 0; i < CHANNELS; i++)
        cnt[i] <= '0;
    end else begin
      sync1 <= Input;
      sync2 <= sync1;
      for (int i = 0; i < CHANNELS; i++) begin
        if (toggle[i]) begin
          Stable[i] <= ~Stable[i];
          cnt[i] <= '0;
        end else if (diff[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else begin
          cnt[i] <= '0;
        end
        // A slot drained on this edge may be refilled on the same edge.
        if (toggle[i] && !ovr_set[i]) begin
          pend_v[i] <= 1'b1;
          pend_t[i] <= ~Stable[i];
        end else if (drain[i]) begin
          pend_v[i] <= 1'b0;
        end
        if (ClearOverrun[i])
          Overrun[i] <= 1'b0;
        else if (ovr_set[i])
          Overrun[i] <= 1'b1;
      end
      if (free) begin
        EventValid <= found;
        if (found) begin
          EventChannel <= pick;
          EventType <= pend_t[pick];
          ptr <= nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_event_arbiter.sv
// Bench for debounce_event_arbiter: directed scenarios plus random
// stimulus, all checked against a cycle-level behavioural model.
module tb_debounce_event_arbiter;

  localparam int N = 4;
  localparam int W = 3;
  localparam int CW = 2;
  localparam int TH = 1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] inp = '0;
  logic [N-1:0] clr = '0;
  logic rdy = 1'b0;

  logic [N-1:0] stable, overrun;
  logic ev_valid, ev_type;
  logic [CW-1:0] ev_chan;

  debounce_event_arbiter #(
    .CHANNELS(N),
    .DEBOUNCER_COUNTER_WIDTH(W)
  ) dut (
    .Clk(clk),
    .Rst_n(rst_n),
    .Input(inp),
    .Stable(stable),
    .EventValid(ev_valid),
    .EventReady(rdy),
    .EventChannel(ev_chan),
    .EventType(ev_type),
    .Overrun(overrun),
    .ClearOverrun(clr)
  );

  always #5 clk = ~clk;

  // model state
  logic [N-1:0] m_s1, m_s2, m_stab, m_pv, m_pt, m_ovr;
  int m_run [N];
  logic m_ev, m_et;
  int m_ch, m_p;

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stab = '0;
    m_pv = '0; m_pt = '0; m_ovr = '0;
    m_ev = 1'b0; m_et = 1'b0; m_ch = 0; m_p = 0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  // One rising edge, using the inputs present before the edge.
  task automatic model_edge();
    logic [N-1:0] tog;
    int c, f;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tog = '0;
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] != m_stab[i]) begin
        m_run[i]++;
        if (m_run[i] == TH) begin
          tog[i] = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (!m_ev || rdy) begin
      f = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_p + k) % N;
        if (f < 0 && m_pv[c]) f = c;
      end
      if (f >= 0) begin
        m_ev = 1'b1;
        m_ch = f;
        m_et = m_pt[f];
        m_pv[f] = 1'b0;
        m_p = (f + 1) % N;
      end else begin
        m_ev = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (tog[i]) begin
        if (m_pv[i]) begin
          if (!clr[i]) m_ovr[i] = 1'b1;
        end else begin
          m_pv[i] = 1'b1;
          m_pt[i] = !m_stab[i];
        end
        m_stab[i] = !m_stab[i];
      end
      if (clr[i]) m_ovr[i] = 1'b0;
    end
    m_s2 = m_s1;
    m_s1 = inp;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("stable", 32'(stable), 32'(m_stab));
    chk("valid", 32'(ev_valid), 32'(m_ev));
    chk("chan", 32'(ev_chan), 32'(m_ch));
    chk("type", 32'(ev_type), 32'(m_et));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  int hold [N];
  int seen_valid;
  int order [3];

  initial begin
    model_reset();
    rst_n = 1'b0;
    steps(3);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_stable", 32'(stable), 32'd0);
    rst_n = 1'b1;
    steps(2);

    // Bouncing input never settles long enough.
    seen_valid = 0;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) inp[0] = ~inp[0];
      step();
      if (ev_valid) seen_valid++;
    end
    inp[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ev_valid) seen_valid++;
    end
    chk("bounce_stable0", 32'(stable[0]), 32'd0);
    chk("bounce_novalid", 32'(seen_valid), 32'd0);

    // Clean press: 10-cycle latency, event one cycle later.
    rdy = 1'b1;
    inp[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 9) chk("lat_early", 32'(stable[1]), 32'd0);
      if (k == 10) chk("lat_exact", 32'(stable[1]), 32'd1);
      if (k == 10) chk("lat_novalid", 32'(ev_valid), 32'd0);
    end
    step();
    chk("press_valid", 32'(ev_valid), 32'd1);
    chk("press_chan", 32'(ev_chan), 32'd1);
    chk("press_type", 32'(ev_type), 32'd1);
    step();
    chk("press_once", 32'(ev_valid), 32'd0);

    // Simultaneous presses, round robin from 0.
    inp = '0;
    do_reset();
    rdy = 1'b1;
    inp = 4'b1101;
    steps(11);
    for (int k = 0; k < 3; k++) begin
      order[k] = ev_valid ? int'(ev_chan) : -1;
      chk("rr_type", 32'(ev_type), 32'd1);
      step();
    end
    chk("rr_first", 32'(order[0]), 32'd0);
    chk("rr_second", 32'(order[1]), 32'd2);
    chk("rr_third", 32'(order[2]), 32'd3);
    chk("rr_drained", 32'(ev_valid), 32'd0);

    // Backpressure, slot hold and overrun.
    inp = '0;
    do_reset();
    rdy = 1'b0;
    inp[2] = 1'b1;
    steps(14);
    chk("bp_valid", 32'(ev_valid), 32'd1);
    inp[2] = 1'b0;
    steps(14);
    inp[2] = 1'b1;
    steps(14);
    chk("bp_ovr", 32'(overrun[2]), 32'd1);
    chk("bp_hold_type", 32'(ev_type), 32'd1);
    chk("bp_hold_chan", 32'(ev_chan), 32'd2);
    rdy = 1'b1;
    step();
    chk("bp_rel_valid", 32'(ev_valid), 32'd1);
    chk("bp_rel_type", 32'(ev_type), 32'd0);
    step();
    chk("bp_empty", 32'(ev_valid), 32'd0);
    clr[2] = 1'b1;
    step();
    clr = '0;
    chk("bp_clr", 32'(overrun[2]), 32'd0);

    // Reset while offering and mid-count.
    rdy = 1'b0;
    inp[2] = 1'b0;
    steps(12);
    chk("mr_valid", 32'(ev_valid), 32'd1);
    inp[3] = 1'b1;
    steps(5);
    do_reset();
    chk("mr_clr_valid", 32'(ev_valid), 32'd0);
    chk("mr_clr_stable", 32'(stable), 32'd0);
    chk("mr_clr_ovr", 32'(overrun), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) chk("mr_first", 32'(ev_valid), 32'd0);
      if (k == 9) chk("mr_early", 32'(stable[3]), 32'd0);
      if (k == 10) chk("mr_exact", 32'(stable[3]), 32'd1);
    end
    step();
    chk("mr_ev_valid", 32'(ev_valid), 32'd1);
    chk("mr_ev_chan", 32'(ev_chan), 32'd3);
    chk("mr_ev_type", 32'(ev_type), 32'd1);

    // Random phase.
    for (int i = 0; i < N; i++) hold[i] = 1;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < N; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          if ($urandom_range(0, 2) != 0) inp[i] = ~inp[i];
          hold[i] = ($urandom_range(0, 3) == 0) ?
                    int'($urandom_range(1, 4)) :
                    int'($urandom_range(6, 30));
        end
      end
      if ((n / 500) % 2 == 1)
        rdy = ($urandom_range(0, 7) == 0);
      else
        rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_n = 1'b1;
    clr = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
